multi_countdown: RTL and testbench
==================================

MULTI_COUNTDOWN -- requirements
Module: multi_countdown

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of independent countdown channels (1-16).
REQ-002 SHALL have parameter MIN_DIGITS, default 2: BCD minute digits per channel (1-4). Seconds are always two digits, 00-59.
REQ-003 SHALL derive localparams CH_W = max(1, clog2(CHANNELS)) and T_W = 4*(MIN_DIGITS+2). Time words are {minute digits MS-first, tens_sec, sec}, 4 bits per digit.
REQ-004 clk  in  1  system clock; one clock domain only.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 tick  in  1  one-clk-wide 1 s count-enable pulse.
REQ-007 global_en  in  1  master enable; when low, no channel decrements.
REQ-008 cmd_valid  in  1  command strobe, sampled each clk.
REQ-009 cmd_op  in  2  command: 00 LOAD, 01 START, 10 PAUSE, 11 CLEAR.
REQ-010 cmd_chan  in  CH_W  target channel.
REQ-011 cmd_time  in  T_W  BCD time for LOAD.
REQ-012 cmd_repeat  in  1  auto-reload flag, captured on LOAD.
REQ-013 rd_chan  in  CH_W  channel selected for readback.
REQ-014 rd_time  out  T_W  current count of rd_chan, combinational mux of registers; 0 if rd_chan >= CHANNELS.
REQ-015 running  out  CHANNELS  bit i high while channel i is in RUN.
REQ-016 done_pulse  out  CHANNELS  one-clk expiry strobe per channel, registered.
REQ-017 alarm  out  CHANNELS  latched expiry flag per channel, registered.

Function
REQ-018 Each channel SHALL hold:
- count (T_W)
- reload (T_W)
- repeat bit
- state: IDLE, RUN, PAUSED or EXPIRED.
REQ-019 Commands SHALL take effect at the clk edge where cmd_valid=1. A cmd_chan >= CHANNELS SHALL be ignored.
REQ-020 LOAD SHALL, from any state:
- saturate cmd_time (minute/sec digit >9 -> 9; tens_sec >5 -> 5)
- write the saturated value to reload and count
- capture the repeat bit
- go to IDLE and clear alarm.
REQ-021 START SHALL, from any state, copy reload to count, clear alarm and go to RUN. If reload is 0, it SHALL instead go to EXPIRED, set alarm and pulse done_pulse on that same edge.
REQ-022 PAUSE SHALL toggle RUN and PAUSED. It SHALL be ignored in IDLE and EXPIRED.
REQ-023 CLEAR SHALL copy reload to count, clear alarm and go to IDLE.
REQ-024 On tick=1 and global_en=1, every channel in RUN SHALL decrement count by one second in BCD:
- sec 0 -> 9, with borrow
- tens_sec 0 -> 5, with borrow
- each minute digit 0 -> 9, with borrow to the next digit up.
REQ-025 When a decrement takes a channel from 00..:01 to zero, that same edge SHALL:
- set done_pulse[i] (high for exactly one clk) and alarm[i]
- if repeat=0: leave count at 0 and go to EXPIRED
- if repeat=1: load count from reload and stay in RUN, so zero is never held.
REQ-026 A command to channel i in the same cycle as tick SHALL take priority over the decrement for channel i only. All other channels SHALL decrement normally.
REQ-027 alarm SHALL stay set until LOAD, START or CLEAR on that channel, or reset.
REQ-028 PAUSED, IDLE and EXPIRED channels SHALL hold count unchanged through tick.
REQ-029 done_pulse SHALL be 0 in every cycle other than those defined in REQ-021 and REQ-025.

Reset
REQ-030 reset=0 SHALL immediately force, on every channel:
- count, reload and repeat to 0
- state to IDLE
- running, done_pulse and alarm to 0.
REQ-031 Reset asserted mid-count SHALL abort all channels. After release, no channel counts until a new LOAD/START.

Verification
REQ-032 CHANNELS=4, MIN_DIGITS=2:
- LOAD ch1 01:00, START ch1, 1 tick -> rd_time(ch1)=00:59.
- 59 more ticks -> count 00:00, done_pulse[1] high for 1 clk, alarm[1]=1, running[1]=0.
REQ-033 LOAD ch0 10:00 with repeat=1, START ch0, 600 ticks -> one done_pulse[0], count=10:00, running[0]=1 throughout.
REQ-034 Pause and global enable on ch2 (RUN at 00:30):
- PAUSE, 10 ticks -> count still 00:30.
- PAUSE again, 5 ticks -> 00:25.
- global_en=0, 5 ticks -> 00:25.
REQ-035 Priority, saturation and bad channel:
- LOAD ch3 with cmd_time=0x9A7C -> reload=99:59.
- START ch3 in the same cycle as tick -> count=99:59, not 99:58.
- Commands to cmd_chan=7 -> no state change on any channel.
REQ-036 Zero START and reset:
- START with reload=0 -> EXPIRED, done_pulse for 1 clk, alarm=1.
- reset low while 3 channels are in RUN -> all outputs 0 with no clk edge.

Source files
------------

// File: rtl/multi_countdown.sv
// multi_countdown: CHANNELS independent BCD mm..m:ss countdown timers.
//
// Ports:
//   clk, reset (async, active low)
//   tick        one-clk 1 s count enable, gated by global_en
//   cmd_*       LOAD/START/PAUSE/CLEAR command to cmd_chan (out-of-range ignored)
//   rd_chan     readback select -> rd_time (0 when out of range)
//   running     per-channel RUN state
//   done_pulse  per-channel one-clk expiry strobe
//   alarm       per-channel latched expiry flag
//
// Time word layout: {minute digits MS-first, tens_sec, sec}, 4 bits each.

// One countdown lane. All command decode for the lane happens here; the top
// only resolves which lane a command addresses.
module multi_countdown_lane #(
  parameter int MIN_DIGITS = 2,
  parameter int T_W        = 4*(MIN_DIGITS+2)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           tick_en,
  input  logic           cmd_hit,
  input  logic [1:0]     cmd_op,
  input  logic [T_W-1:0] cmd_time,
  input  logic           cmd_repeat,
  output logic [T_W-1:0] count,
  output logic           running,
  output logic           done_pulse,
  output logic           alarm
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_EXP} state_t;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_START = 2'b01;
  localparam logic [1:0] OP_PAUSE = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  // Digit 1 is tens-of-seconds (0-5); every other digit is 0-9.
  function automatic logic [T_W-1:0] bcd_sat(input logic [T_W-1:0] t);
    logic [T_W-1:0] r;
    logic [3:0]     d, top;
    r = t;
    for (int k = 0; k < MIN_DIGITS+2; k++) begin
      d   = t[4*k +: 4];
      top = (k == 1) ? 4'd5 : 4'd9;
      if (d > top) r[4*k +: 4] = top;
    end
    return r;
  endfunction

  // Ripple-borrow one-second decrement from the seconds digit upward.
  function automatic logic [T_W-1:0] bcd_dec(input logic [T_W-1:0] t);
    logic [T_W-1:0] r;
    logic           borrow;
    logic [3:0]     d, top;
    r      = t;
    borrow = 1'b1;
    for (int k = 0; k < MIN_DIGITS+2; k++) begin
      d   = t[4*k +: 4];
      top = (k == 1) ? 4'd5 : 4'd9;
      if (borrow) begin
        if (d == 4'd0) r[4*k +: 4] = top;
        else begin
          r[4*k +: 4] = d - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  localparam logic [T_W-1:0] ONE_SEC = T_W'(1);

  state_t         state;
  logic [T_W-1:0] reload;
  logic           rep;

  assign running = (state == S_RUN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      count      <= '0;
      reload     <= '0;
      rep        <= 1'b0;
      done_pulse <= 1'b0;
      alarm      <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      // A command to this lane wins over a coincident tick.
      if (cmd_hit) begin
        unique case (cmd_op)
          OP_LOAD: begin
            reload <= bcd_sat(cmd_time);
            count  <= bcd_sat(cmd_time);
            rep    <= cmd_repeat;
            state  <= S_IDLE;
            alarm  <= 1'b0;
          end
          OP_START: begin
            count <= reload;
            if (reload == '0) begin
              // Nothing to count: expire immediately.
              state      <= S_EXP;
              alarm      <= 1'b1;
              done_pulse <= 1'b1;
            end else begin
              state <= S_RUN;
              alarm <= 1'b0;
            end
          end
          OP_PAUSE: begin
            if (state == S_RUN)         state <= S_PAUSED;
            else if (state == S_PAUSED) state <= S_RUN;
          end
          OP_CLEAR: begin
            count <= reload;
            alarm <= 1'b0;
            state <= S_IDLE;
          end
          default: ;
        endcase
      end else if (tick_en && state == S_RUN) begin
        if (count == ONE_SEC) begin
          done_pulse <= 1'b1;
          alarm      <= 1'b1;
          // Repeat reloads on the expiry edge so zero is never held.
          if (rep) count <= reload;
          else begin
            count <= '0;
            state <= S_EXP;
          end
        end else begin
          count <= bcd_dec(count);
        end
      end
    end
  end
endmodule

module multi_countdown #(
  parameter int CHANNELS   = 4,
  parameter int MIN_DIGITS = 2,
  localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int T_W       = 4*(MIN_DIGITS+2)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic                global_en,
  input  logic                cmd_valid,
  input  logic [1:0]          cmd_op,
  input  logic [CH_W-1:0]     cmd_chan,
  input  logic [T_W-1:0]      cmd_time,
  input  logic                cmd_repeat,
  input  logic [CH_W-1:0]     rd_chan,
  output logic [T_W-1:0]      rd_time,
  output logic [CHANNELS-1:0] running,
  output logic [CHANNELS-1:0] done_pulse,
  output logic [CHANNELS-1:0] alarm
);
  logic                          tick_en;
  logic [CHANNELS-1:0]           cmd_hit;
  logic [CHANNELS-1:0][T_W-1:0]  cnt;

  assign tick_en = tick & global_en;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    // Out-of-range cmd_chan matches no lane and is thereby ignored.
    assign cmd_hit[i] = cmd_valid && (cmd_chan == CH_W'(i));

    multi_countdown_lane #(
      .MIN_DIGITS (MIN_DIGITS),
      .T_W        (T_W)
    ) u_lane (
      .clk        (clk),
      .reset      (reset),
      .tick_en    (tick_en),
      .cmd_hit    (cmd_hit[i]),
      .cmd_op     (cmd_op),
      .cmd_time   (cmd_time),
      .cmd_repeat (cmd_repeat),
      .count      (cnt[i]),
      .running    (running[i]),
      .done_pulse (done_pulse[i]),
      .alarm      (alarm[i])
    );
  end

  always_comb begin
    rd_time = '0;
    for (int i = 0; i < CHANNELS; i++)
      if (rd_chan == CH_W'(i)) rd_time = cnt[i];
  end
endmodule

// File: tb/tb_multi_countdown.sv
module tb_multi_countdown;
  localparam int NCH = 4;
  localparam int MD  = 2;
  localparam logic [1:0] LOAD = 2'b00, START = 2'b01, PAUSE = 2'b10, CLEAR = 2'b11;
  localparam int ST_IDLE = 0, ST_RUN = 1, ST_PAUSED = 2, ST_EXP = 3;

  logic        clk = 0, reset = 0, tick = 0, global_en = 1;
  logic        cmd_valid = 0, cmd_repeat = 0;
  logic [1:0]  cmd_op = 0, cmd_chan = 0, rd_chan = 0;
  logic [15:0] cmd_time = 0, rd_time;
  logic [3:0]  running, done_pulse, alarm;

  // Second instance with a 3-bit channel field to exercise out-of-range channels.
  logic        c2_valid = 0, c2_rep = 0;
  logic [1:0]  c2_op = 0;
  logic [2:0]  c2_chan = 0, rd2_chan = 0;
  logic [11:0] c2_time = 0, rd2_time;
  logic [4:0]  run2, done2, alarm2;

  always #5 clk = ~clk;

  multi_countdown #(.CHANNELS(NCH), .MIN_DIGITS(MD)) dut (
    .clk(clk), .reset(reset), .tick(tick), .global_en(global_en),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_chan(cmd_chan),
    .cmd_time(cmd_time), .cmd_repeat(cmd_repeat), .rd_chan(rd_chan),
    .rd_time(rd_time), .running(running), .done_pulse(done_pulse), .alarm(alarm));

  multi_countdown #(.CHANNELS(5), .MIN_DIGITS(1)) dut2 (
    .clk(clk), .reset(reset), .tick(tick), .global_en(global_en),
    .cmd_valid(c2_valid), .cmd_op(c2_op), .cmd_chan(c2_chan),
    .cmd_time(c2_time), .cmd_repeat(c2_rep), .rd_chan(rd2_chan),
    .rd_time(rd2_time), .running(run2), .done_pulse(done2), .alarm(alarm2));

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---- model: counts held as plain seconds ----
  int m_cnt[NCH], m_rel[NCH], m_st[NCH];
  bit m_rep[NCH], m_al[NCH], m_dn[NCH];

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int sat_secs(input logic [15:0] t);
    int mins = 0;
    for (int k = MD-1; k >= 0; k--) mins = mins*10 + min_i(int'(t[8+4*k +: 4]), 9);
    return mins*60 + min_i(int'(t[7:4]), 5)*10 + min_i(int'(t[3:0]), 9);
  endfunction

  function automatic logic [15:0] to_bcd(input int s);
    logic [15:0] r;
    int m = s / 60, rs = s % 60, p = 1;
    r[3:0] = 4'(rs % 10);
    r[7:4] = 4'(rs / 10);
    for (int k = 0; k < MD; k++) begin
      r[8+4*k +: 4] = 4'((m / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  task automatic model_step();
    for (int i = 0; i < NCH; i++) begin
      m_dn[i] = 0;
      if (!reset) begin
        m_cnt[i] = 0; m_rel[i] = 0; m_rep[i] = 0; m_st[i] = ST_IDLE; m_al[i] = 0;
      end else if (cmd_valid && int'(cmd_chan) == i) begin
        case (cmd_op)
          LOAD: begin
            m_rel[i] = sat_secs(cmd_time); m_cnt[i] = m_rel[i];
            m_rep[i] = cmd_repeat; m_st[i] = ST_IDLE; m_al[i] = 0;
          end
          START: begin
            m_cnt[i] = m_rel[i];
            if (m_rel[i] == 0) begin m_st[i] = ST_EXP; m_al[i] = 1; m_dn[i] = 1; end
            else begin m_st[i] = ST_RUN; m_al[i] = 0; end
          end
          PAUSE: begin
            if (m_st[i] == ST_RUN) m_st[i] = ST_PAUSED;
            else if (m_st[i] == ST_PAUSED) m_st[i] = ST_RUN;
          end
          default: begin m_cnt[i] = m_rel[i]; m_al[i] = 0; m_st[i] = ST_IDLE; end
        endcase
      end else if (tick && global_en && m_st[i] == ST_RUN) begin
        m_cnt[i]--;
        if (m_cnt[i] == 0) begin
          m_dn[i] = 1; m_al[i] = 1;
          if (m_rep[i]) m_cnt[i] = m_rel[i];
          else m_st[i] = ST_EXP;
        end
      end
    end
  endtask

  always @(posedge clk) begin
    logic [3:0] er, ed, ea;
    model_step();
    #1;
    for (int i = 0; i < NCH; i++) begin
      er[i] = (m_st[i] == ST_RUN); ed[i] = m_dn[i]; ea[i] = m_al[i];
    end
    chk("model running", running, er);
    chk("model done_pulse", done_pulse, ed);
    chk("model alarm", alarm, ea);
    chk("model rd_time", rd_time, to_bcd(m_cnt[rd_chan]));
  end

  // ---- stimulus ----
  task automatic cyc(input logic v, input logic [1:0] op, input logic [1:0] ch,
                     input logic [15:0] t, input logic rp, input logic tk);
    @(negedge clk);
    cmd_valid = v; cmd_op = op; cmd_chan = ch; cmd_time = t; cmd_repeat = rp;
    tick = tk; c2_valid = 0;
    @(posedge clk); #2;
  endtask
  task automatic idle();  cyc(0, LOAD, 0, 0, 0, 0); endtask
  task automatic tk1();   cyc(0, LOAD, 0, 0, 0, 1); endtask
  task automatic cmd(input logic [1:0] op, input logic [1:0] ch, input logic [15:0] t, input logic rp);
    cyc(1, op, ch, t, rp, 0);
  endtask
  task automatic ticks(input int n);
    repeat (n) begin tk1(); idle(); end
  endtask
  task automatic cyc2(input logic [1:0] op, input logic [2:0] ch, input logic [11:0] t);
    @(negedge clk);
    cmd_valid = 0; tick = 0;
    c2_valid = 1; c2_op = op; c2_chan = ch; c2_time = t; c2_rep = 0;
    @(posedge clk); #2;
    c2_valid = 0;
  endtask

  initial begin
    int dn_cnt;
    bit all_run;
    // reset state
    repeat (3) idle();
    chk("reset running", running, 0);
    chk("reset alarm", alarm, 0);
    chk("reset done", done_pulse, 0);
    chk("reset rd_time", rd_time, 0);
    @(negedge clk) reset = 1;

    // ch1 01:00 one-shot
    rd_chan = 1;
    cmd(LOAD, 1, 16'h0100, 0);
    cmd(START, 1, 0, 0);
    ticks(1);
    chk("ch1 first tick", rd_time, 16'h0059);
    ticks(58);
    chk("ch1 at 00:01", rd_time, 16'h0001);
    tk1();
    chk("ch1 expiry done", done_pulse[1], 1);
    chk("ch1 expiry alarm", alarm[1], 1);
    chk("ch1 expiry running", running[1], 0);
    chk("ch1 expiry count", rd_time, 16'h0000);
    idle();
    chk("ch1 done one clk", done_pulse[1], 0);
    chk("ch1 alarm latched", alarm[1], 1);

    // ch0 10:00 with repeat
    rd_chan = 0;
    cmd(LOAD, 0, 16'h1000, 1);
    cmd(START, 0, 0, 0);
    dn_cnt = 0; all_run = 1;
    repeat (600) begin
      tk1();  dn_cnt += int'(done_pulse[0]); all_run &= running[0];
      idle(); dn_cnt += int'(done_pulse[0]); all_run &= running[0];
    end
    chk("ch0 repeat pulses", dn_cnt, 1);
    chk("ch0 repeat reload", rd_time, 16'h1000);
    chk("ch0 running throughout", all_run, 1);

    // ch2 pause / global enable
    rd_chan = 2;
    cmd(LOAD, 2, 16'h0030, 0);
    cmd(START, 2, 0, 0);
    cmd(PAUSE, 2, 0, 0);
    ticks(10);
    chk("ch2 paused hold", rd_time, 16'h0030);
    chk("ch2 paused not running", running[2], 0);
    cmd(PAUSE, 2, 0, 0);
    ticks(5);
    chk("ch2 resumed", rd_time, 16'h0025);
    global_en = 0;
    ticks(5);
    chk("ch2 global_en off", rd_time, 16'h0025);
    global_en = 1;

    // ch3 saturation and command-over-tick priority
    rd_chan = 3;
    cmd(LOAD, 3, 16'h9A7C, 0);
    chk("ch3 saturated load", rd_time, 16'h9959);
    cyc(1, START, 3, 0, 0, 1);
    chk("ch3 start beats tick", rd_time, 16'h9959);
    chk("ch3 running", running[3], 1);
    ticks(1);
    chk("ch3 first decrement", rd_time, 16'h9958);

    // zero-reload START on ch1
    cmd(LOAD, 1, 16'h0000, 0);
    cmd(START, 1, 0, 0);
    chk("zero start done", done_pulse[1], 1);
    chk("zero start alarm", alarm[1], 1);
    chk("zero start running", running[1], 0);
    idle();
    chk("zero start done one clk", done_pulse[1], 0);

    // asynchronous reset with three channels running
    chk("pre-reset running", running, 4'b1101);
    reset = 0;
    #1;
    chk("async reset running", running, 0);
    chk("async reset alarm", alarm, 0);
    chk("async reset done", done_pulse, 0);
    chk("async reset rd_time", rd_time, 0);
    idle(); idle();
    @(negedge clk) reset = 1;
    ticks(3);
    chk("post-reset running", running, 0);
    for (int i = 0; i < NCH; i++) begin
      rd_chan = 2'(i); #1;
      chk("post-reset count", rd_time, 0);
    end

    // out-of-range channels on the 5-channel instance
    rd2_chan = 4;
    cyc2(LOAD, 4, 12'h530);
    chk("dut2 load ch4", rd2_time, 12'h530);
    cyc2(START, 4, 0);
    chk("dut2 start ch4", run2, 5'b10000);
    cyc2(CLEAR, 7, 0);
    cyc2(LOAD, 5, 12'h100);
    cyc2(PAUSE, 6, 0);
    cyc2(START, 7, 0);
    chk("dut2 bad chan count", rd2_time, 12'h530);
    chk("dut2 bad chan running", run2, 5'b10000);
    chk("dut2 bad chan alarm", alarm2, 0);
    rd2_chan = 7; #1;
    chk("dut2 rd out of range", rd2_time, 0);

    idle();
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
